// File: rtl/red_pitaya_relock_pkg.sv
`default_nettype none
// ============================================================================
// Module  : red_pitaya_relock_pkg
// Brief   : Shared state encoding, register offsets and reset values for the
//           relock sequencer.
// Revision: 1.0
// ============================================================================
package red_pitaya_relock_pkg;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_MONITOR  = 2'd1,
        ST_SWEEP    = 2'd2,
        ST_SETTLE   = 2'd3
    } state_t;

    localparam logic [19:0] REG_CTRL          = 20'h00;
    localparam logic [19:0] REG_RAIL_CYCLES   = 20'h04;
    localparam logic [19:0] REG_SWEEP_MIN     = 20'h08;
    localparam logic [19:0] REG_SWEEP_MAX     = 20'h0C;
    localparam logic [19:0] REG_SWEEP_STEP    = 20'h10;
    localparam logic [19:0] REG_LOCK_MIN      = 20'h14;
    localparam logic [19:0] REG_SETTLE_CYCLES = 20'h18;
    localparam logic [19:0] REG_STATUS        = 20'h1C;
    localparam logic [19:0] REG_RELOCK_CNT    = 20'h20;

    localparam int RST_RAIL_CYCLES   = 1000;
    localparam int RST_SETTLE_CYCLES = 1000;
    localparam int RST_SWEEP_MIN     = -8192;
    localparam int RST_SWEEP_MAX     = 8191;
    localparam int RST_SWEEP_STEP    = 1;
    localparam int RST_LOCK_MIN      = 0;

endpackage
`default_nettype wire

// File: rtl/red_pitaya_relock_ramp.sv
`default_nettype none
// ============================================================================
// Module  : red_pitaya_relock_ramp
// Brief   : Bounded triangle ramp between min_val and max_val, clamping at
//           both ends and reversing direction there.
// Revision: 1.0
// ============================================================================
module red_pitaya_relock_ramp #(
    parameter int DW = 14
)(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr,
    input  logic                 load,
    input  logic                 run,
    input  logic signed [DW-1:0] min_val,
    input  logic signed [DW-1:0] max_val,
    input  logic        [DW-1:0] step,
    output logic signed [DW-1:0] value,
    output logic                 dir_down
);

    // Two guard bits: value plus a full-range unsigned step can exceed DW+1 bits.
    logic signed [DW+1:0] w_val;
    logic signed [DW+1:0] w_min;
    logic signed [DW+1:0] w_max;
    logic signed [DW+1:0] w_step;
    logic signed [DW+1:0] w_up;
    logic signed [DW+1:0] w_dn;

    assign w_val  = {{2{value[DW-1]}}, value};
    assign w_min  = {{2{min_val[DW-1]}}, min_val};
    assign w_max  = {{2{max_val[DW-1]}}, max_val};
    assign w_step = {2'b00, step};
    assign w_up   = w_val + w_step;
    assign w_dn   = w_val - w_step;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            value    <= '0;
            dir_down <= 1'b0;
        end else if (clr) begin
            value    <= '0;
            dir_down <= 1'b0;
        end else if (load) begin
            value    <= min_val;
            dir_down <= 1'b0;
        end else if (run) begin
            if (w_min >= w_max) begin
                value    <= min_val;
                dir_down <= 1'b0;
            end else if (!dir_down) begin
                if (w_up >= w_max) begin
                    value    <= max_val;
                    dir_down <= 1'b1;
                end else begin
                    value    <= w_up[DW-1:0];
                end
            end else begin
                if (w_dn <= w_min) begin
                    value    <= min_val;
                    dir_down <= 1'b0;
                end else begin
                    value    <= w_dn[DW-1:0];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/red_pitaya_relock.sv
`default_nettype none
// ============================================================================
// Module  : red_pitaya_relock
// Brief   : Relock sequencer: detects sustained rails, sweeps an offset ramp
//           with the integrator held in reset until lock, then settles.
//           Optional macro RELOCK_STATS_EN adds a relock counter at 0x20.
// Revision: 1.0
// ============================================================================
module red_pitaya_relock
    import red_pitaya_relock_pkg::*;
#(
    parameter int CW = 24,
    parameter int DW = 14
)(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [1:0]           railed_i,
    input  logic signed [DW-1:0] sig_i,
    output logic signed [DW-1:0] sweep_o,
    output logic                 int_rst_o,
    output logic                 active_o,
    input  logic [31:0]          sys_addr,
    input  logic [31:0]          sys_wdata,
    input  logic                 sys_wen,
    input  logic                 sys_ren,
    output logic [31:0]          sys_rdata,
    output logic                 sys_err,
    output logic                 sys_ack
);

    logic          r_enable;
    logic          r_force;
    logic [CW-1:0] r_rail_cycles;
    logic [CW-1:0] r_settle_cycles;
    logic [DW-1:0] r_sweep_min;
    logic [DW-1:0] r_sweep_max;
    logic [DW-1:0] r_sweep_step;
    logic [DW-1:0] r_lock_min;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_int_rst;
    logic          r_active;
    logic [31:0]   r_rdata;
    logic          r_ack;

    logic [19:0]   w_addr;
    logic [CW-1:0] w_rail_lim;
    logic [CW-1:0] w_settle_lim;
    logic          w_rail;
    logic          w_lock;
    logic          w_enter_sweep;
    logic          w_ramp_clr;
    logic          w_ramp_load;
    logic          w_ramp_run;
    logic          w_dir_down;
    logic [31:0]   w_rdata;

    assign w_addr        = sys_addr[19:0];
    assign w_rail_lim    = (r_rail_cycles == '0) ? '0 : r_rail_cycles - CW'(1);
    assign w_settle_lim  = (r_settle_cycles == '0) ? '0 : r_settle_cycles - CW'(1);
    assign w_rail        = |railed_i;
    assign w_lock        = $signed(sig_i) >= $signed(r_lock_min);
    assign w_enter_sweep = (r_state == ST_MONITOR) && (r_force || (w_rail && (r_cnt >= w_rail_lim)));
    assign w_ramp_clr    = !r_enable;
    assign w_ramp_load   = r_enable && (w_enter_sweep || ((r_state == ST_SETTLE) && r_force));
    assign w_ramp_run    = r_enable && (r_state == ST_SWEEP);

    red_pitaya_relock_ramp #(.DW(DW)) u_ramp (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr      (w_ramp_clr),
        .load     (w_ramp_load),
        .run      (w_ramp_run),
        .min_val  (r_sweep_min),
        .max_val  (r_sweep_max),
        .step     (r_sweep_step),
        .value    (sweep_o),
        .dir_down (w_dir_down)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_enable        <= 1'b0;
            r_force         <= 1'b0;
            r_rail_cycles   <= CW'(RST_RAIL_CYCLES);
            r_settle_cycles <= CW'(RST_SETTLE_CYCLES);
            r_sweep_min     <= DW'(RST_SWEEP_MIN);
            r_sweep_max     <= DW'(RST_SWEEP_MAX);
            r_sweep_step    <= DW'(RST_SWEEP_STEP);
            r_lock_min      <= DW'(RST_LOCK_MIN);
        end else begin
            r_force <= 1'b0;
            if (sys_wen) begin
                case (w_addr)
                    REG_CTRL: begin
                        r_enable <= sys_wdata[0];
                        r_force  <= sys_wdata[1];
                    end
                    REG_RAIL_CYCLES:   r_rail_cycles   <= sys_wdata[CW-1:0];
                    REG_SWEEP_MIN:     r_sweep_min     <= sys_wdata[DW-1:0];
                    REG_SWEEP_MAX:     r_sweep_max     <= sys_wdata[DW-1:0];
                    REG_SWEEP_STEP:    r_sweep_step    <= sys_wdata[DW-1:0];
                    REG_LOCK_MIN:      r_lock_min      <= sys_wdata[DW-1:0];
                    REG_SETTLE_CYCLES: r_settle_cycles <= sys_wdata[CW-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Outputs take their value for the state being entered on the same edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_DISABLED;
            r_cnt     <= '0;
            r_int_rst <= 1'b0;
            r_active  <= 1'b0;
        end else if (!r_enable) begin
            r_state   <= ST_DISABLED;
            r_cnt     <= '0;
            r_int_rst <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            case (r_state)
                ST_DISABLED: begin
                    r_state <= ST_MONITOR;
                    r_cnt   <= '0;
                end
                ST_MONITOR: begin
                    if (w_enter_sweep) begin
                        r_state   <= ST_SWEEP;
                        r_cnt     <= '0;
                        r_int_rst <= 1'b1;
                        r_active  <= 1'b1;
                    end else if (w_rail) begin
                        r_cnt <= r_cnt + CW'(1);
                    end else begin
                        r_cnt <= '0;
                    end
                end
                ST_SWEEP: begin
                    if (w_lock) begin
                        r_state   <= ST_SETTLE;
                        r_cnt     <= '0;
                        r_int_rst <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (w_rail || r_force) begin
                        r_state   <= ST_SWEEP;
                        r_cnt     <= '0;
                        r_int_rst <= 1'b1;
                    end else if (r_cnt >= w_settle_lim) begin
                        r_state  <= ST_MONITOR;
                        r_cnt    <= '0;
                        r_active <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= ST_DISABLED;
            endcase
        end
    end

`ifdef RELOCK_STATS_EN
    logic [31:0] r_relock_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_relock_cnt <= '0;
        end else if (sys_wen && (w_addr == REG_RELOCK_CNT)) begin
            r_relock_cnt <= '0;
        end else if (r_enable && w_enter_sweep && (r_relock_cnt != '1)) begin
            r_relock_cnt <= r_relock_cnt + 32'd1;
        end
    end
`endif

    always_comb begin
        w_rdata = '0;
        case (w_addr)
            REG_CTRL:          w_rdata = {31'd0, r_enable};
            REG_RAIL_CYCLES:   w_rdata = 32'(r_rail_cycles);
            REG_SWEEP_MIN:     w_rdata = 32'(r_sweep_min);
            REG_SWEEP_MAX:     w_rdata = 32'(r_sweep_max);
            REG_SWEEP_STEP:    w_rdata = 32'(r_sweep_step);
            REG_LOCK_MIN:      w_rdata = 32'(r_lock_min);
            REG_SETTLE_CYCLES: w_rdata = 32'(r_settle_cycles);
            REG_STATUS:        w_rdata = {28'd0, w_dir_down, 1'b0, r_state};
`ifdef RELOCK_STATS_EN
            REG_RELOCK_CNT:    w_rdata = r_relock_cnt;
`else
            REG_RELOCK_CNT:    w_rdata = '0;
`endif
            default:           w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= sys_wen | sys_ren;
            r_rdata <= sys_ren ? w_rdata : '0;
        end
    end

    assign int_rst_o = r_int_rst;
    assign active_o  = r_active;
    assign sys_ack   = r_ack;
    assign sys_rdata = r_rdata;
    assign sys_err   = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_relock.sv
`default_nettype none
// ============================================================================
// Module  : tb_red_pitaya_relock
// Brief   : Self-checking bench for the relock sequencer with a cycle model.
// Revision: 1.0
// ============================================================================
module tb_red_pitaya_relock;

    localparam int CW = 24;
    localparam int DW = 14;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [1:0]           railed_i = '0;
    logic signed [DW-1:0] sig_i = '0;
    logic signed [DW-1:0] sweep_o;
    logic                 int_rst_o;
    logic                 active_o;
    logic [31:0]          sys_addr = '0;
    logic [31:0]          sys_wdata = '0;
    logic                 sys_wen = 1'b0;
    logic                 sys_ren = 1'b0;
    logic [31:0]          sys_rdata;
    logic                 sys_err;
    logic                 sys_ack;

    always #5 clk = ~clk;

    red_pitaya_relock #(.CW(CW), .DW(DW)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .railed_i  (railed_i),
        .sig_i     (sig_i),
        .sweep_o   (sweep_o),
        .int_rst_o (int_rst_o),
        .active_o  (active_o),
        .sys_addr  (sys_addr),
        .sys_wdata (sys_wdata),
        .sys_wen   (sys_wen),
        .sys_ren   (sys_ren),
        .sys_rdata (sys_rdata),
        .sys_err   (sys_err),
        .sys_ack   (sys_ack)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: states 0=disabled 1=monitor 2=sweep 3=settle, direction +1/-1
    int     m_state, m_cnt, m_sweep, m_dir, m_int_rst, m_active;
    int     m_en, m_force, m_rail_cyc, m_settle_cyc, m_min, m_max, m_step, m_lock;
    longint m_relocks;

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_sweep = 0; m_dir = 1; m_int_rst = 0; m_active = 0;
        m_en = 0; m_force = 0; m_rail_cyc = 1000; m_settle_cyc = 1000;
        m_min = -8192; m_max = 8191; m_step = 1; m_lock = 0; m_relocks = 0;
    endtask

    task automatic ramp_advance();
        int n;
        if (m_min >= m_max) begin
            m_sweep = m_min;
            m_dir   = 1;
        end else if (m_dir > 0) begin
            n = m_sweep + m_step;
            if (n >= m_max) begin m_sweep = m_max; m_dir = -1; end
            else m_sweep = n;
        end else begin
            n = m_sweep - m_step;
            if (n <= m_min) begin m_sweep = m_min; m_dir = 1; end
            else m_sweep = n;
        end
    endtask

    task automatic start_sweep_from_min();
        m_state = 2; m_cnt = 0; m_sweep = m_min; m_dir = 1; m_int_rst = 1; m_active = 1;
    endtask

    task automatic model_step();
        int rail, lock, s, rlim, slim;
        rail = (railed_i != 2'b00);
        s    = sig_i;
        lock = (s >= m_lock);
        rlim = (m_rail_cyc > 1) ? m_rail_cyc - 1 : 0;
        slim = (m_settle_cyc > 1) ? m_settle_cyc - 1 : 0;
        if (!m_en) begin
            m_state = 0; m_cnt = 0; m_sweep = 0; m_dir = 1; m_int_rst = 0; m_active = 0;
        end else begin
            case (m_state)
                0: begin m_state = 1; m_cnt = 0; end
                1: begin
                    if (m_force || (rail && m_cnt >= rlim)) begin
                        start_sweep_from_min();
                        if (m_relocks < 64'hFFFF_FFFF) m_relocks++;
                    end else begin
                        m_cnt = rail ? m_cnt + 1 : 0;
                    end
                end
                2: begin
                    ramp_advance();
                    if (lock) begin m_state = 3; m_cnt = 0; m_int_rst = 0; end
                end
                default: begin
                    if (m_force) start_sweep_from_min();
                    else if (rail) begin m_state = 2; m_cnt = 0; m_int_rst = 1; end
                    else if (m_cnt >= slim) begin m_state = 1; m_cnt = 0; m_active = 0; end
                    else m_cnt++;
                end
            endcase
        end
        m_force = 0;
        if (sys_wen) begin
            case (sys_addr[19:0])
                20'h00: begin m_en = sys_wdata[0]; m_force = sys_wdata[1]; end
                20'h04: m_rail_cyc   = sys_wdata[CW-1:0];
                20'h08: m_min        = $signed(sys_wdata[DW-1:0]);
                20'h0C: m_max        = $signed(sys_wdata[DW-1:0]);
                20'h10: m_step       = sys_wdata[DW-1:0];
                20'h14: m_lock       = $signed(sys_wdata[DW-1:0]);
                20'h18: m_settle_cyc = sys_wdata[CW-1:0];
`ifdef RELOCK_STATS_EN
                20'h20: m_relocks    = 0;
`endif
                default: ;
            endcase
        end
    endtask

    function automatic int exp_status();
        return (m_dir < 0 ? 8 : 0) | m_state;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
        tick();
        sys_wen = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        sys_addr = a; sys_ren = 1'b1;
        tick();
        d = sys_rdata;
        sys_ren = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        n_checks++; if (sweep_o !== '0)   begin n_errors++; $display("FAIL reset_sweep: got %0d want 0", sweep_o); end
        n_checks++; if (int_rst_o !== 1'b0) begin n_errors++; $display("FAIL reset_int_rst: got %b want 0", int_rst_o); end
        n_checks++; if (active_o !== 1'b0)  begin n_errors++; $display("FAIL reset_active: got %b want 0", active_o); end
        n_checks++; if (sys_ack !== 1'b0)   begin n_errors++; $display("FAIL reset_ack: got %b want 0", sys_ack); end
        n_checks++; if (sys_err !== 1'b0)   begin n_errors++; $display("FAIL reset_err: got %b want 0", sys_err); end
        n_checks++; if (sys_rdata !== '0)   begin n_errors++; $display("FAIL reset_rdata: got %h want 0", sys_rdata); end
        rst = 1'b0;
        bus_read(32'h1C, d);
        n_checks++; if (d !== 32'd0) begin n_errors++; $display("FAIL reset_status: got %h want 0", d); end
        bus_read(32'h04, d);
        n_checks++; if (d !== 32'd1000) begin n_errors++; $display("FAIL reset_rail_cycles: got %0d want 1000", d); end
        bus_read(32'h08, d);
        n_checks++; if (d !== 32'h2000) begin n_errors++; $display("FAIL reset_sweep_min: got %h want 2000", d); end
        bus_read(32'h0C, d);
        n_checks++; if (d !== 32'h1FFF) begin n_errors++; $display("FAIL reset_sweep_max: got %h want 1fff", d); end
        bus_read(32'h18, d);
        n_checks++; if (d !== 32'd1000) begin n_errors++; $display("FAIL reset_settle: got %0d want 1000", d); end
    endtask

    task automatic test_short_rail();
        logic [31:0] d;
        sig_i = -14'sd8000;
        bus_write(32'h04, 32'd5);
        bus_write(32'h18, 32'd10);
        bus_write(32'h00, 32'd1);
        tick();
        railed_i = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (int_rst_o !== 1'b0) begin n_errors++; $display("FAIL short_rail_int_rst: cycle %0d got %b want 0", i, int_rst_o); end
        end
        railed_i = 2'b00;
        tick();
        bus_read(32'h1C, d);
        n_checks++; if (d !== 32'd1) begin n_errors++; $display("FAIL short_rail_state: got %h want 1", d); end
    endtask

    task automatic test_rail_sweep();
        int n = 0;
        railed_i = 2'b10;
        while (int_rst_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        n_checks++; if (n != 5) begin n_errors++; $display("FAIL rail_sweep_latency: got %0d cycles want 5", n); end
        n_checks++; if (sweep_o !== -14'sd8192) begin n_errors++; $display("FAIL rail_sweep_start: got %0d want -8192", sweep_o); end
        n_checks++; if (active_o !== 1'b1) begin n_errors++; $display("FAIL rail_sweep_active: got %b want 1", active_o); end
        tick();
        n_checks++; if (sweep_o !== -14'sd8191) begin n_errors++; $display("FAIL rail_sweep_step1: got %0d want -8191", sweep_o); end
        tick();
        n_checks++; if (sweep_o !== -14'sd8190) begin n_errors++; $display("FAIL rail_sweep_step2: got %0d want -8190", sweep_o); end
        railed_i = 2'b00;
    endtask

    task automatic test_triangle();
        int exp_tri[15] = '{-100, -70, -40, -10, 20, 50, 80, 100, 70, 40, 10, -20, -50, -80, -100};
        bus_write(32'h00, 32'd0);
        bus_write(32'h08, 32'(-100));
        bus_write(32'h0C, 32'd100);
        bus_write(32'h10, 32'd30);
        bus_write(32'h00, 32'd1);
        tick();
        bus_write(32'h00, 32'd3);
        tick();
        for (int i = 0; i < 15; i++) begin
            n_checks++;
            if (sweep_o !== exp_tri[i] || sweep_o !== m_sweep) begin
                n_errors++;
                $display("FAIL triangle_seq[%0d]: got %0d want %0d (model %0d)", i, sweep_o, exp_tri[i], m_sweep);
            end
            if (i < 14) tick();
        end
    endtask

    task automatic lock_at_twenty(input string tag);
        int n = 0;
        while (sweep_o !== -14'sd10 && n < 40) begin
            tick();
            n++;
        end
        n_checks++; if (sweep_o !== -14'sd10) begin n_errors++; $display("FAIL %s_reach: got %0d want -10", tag, sweep_o); end
        sig_i = 14'sd0;
        tick();
        sig_i = -14'sd8000;
        n_checks++; if (sweep_o !== 14'sd20 || int_rst_o !== 1'b0 || active_o !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_lock: got sweep=%0d int_rst=%b active=%b want 20/0/1", tag, sweep_o, int_rst_o, active_o);
        end
    endtask

    task automatic test_lock_settle();
        logic [31:0] d;
        bus_write(32'h18, 32'd10);
        lock_at_twenty("settle");
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_checks++;
            if (active_o !== (k < 10) || sweep_o !== 14'sd20 || active_o !== m_active[0]) begin
                n_errors++;
                $display("FAIL settle_cycle[%0d]: got active=%b sweep=%0d want active=%0d sweep=20", k, active_o, sweep_o, (k < 10));
            end
        end
        bus_read(32'h1C, d);
        n_checks++; if (d !== 32'd1 || sweep_o !== 14'sd20) begin n_errors++; $display("FAIL settle_to_monitor: got status=%h sweep=%0d want 1/20", d, sweep_o); end
    endtask

    task automatic test_rail_beats_settle();
        bus_write(32'h00, 32'd3);
        lock_at_twenty("rail_win");
        repeat (9) tick();
        railed_i = 2'b01;
        tick();
        railed_i = 2'b00;
        n_checks++; if (int_rst_o !== 1'b1 || active_o !== 1'b1 || sweep_o !== 14'sd20) begin
            n_errors++;
            $display("FAIL rail_win_sweep: got int_rst=%b active=%b sweep=%0d want 1/1/20", int_rst_o, active_o, sweep_o);
        end
        tick();
        n_checks++; if (sweep_o !== 14'sd50) begin n_errors++; $display("FAIL rail_win_resume: got %0d want 50", sweep_o); end
    endtask

    task automatic test_disable_and_reset();
        logic [31:0] d;
        bus_write(32'h00, 32'd0);
        tick();
        n_checks++; if (sweep_o !== '0 || int_rst_o !== 1'b0 || active_o !== 1'b0) begin
            n_errors++;
            $display("FAIL disable: got sweep=%0d int_rst=%b active=%b want 0/0/0", sweep_o, int_rst_o, active_o);
        end
        bus_write(32'h20, 32'd0);
        bus_write(32'h00, 32'd1);
        tick();
        bus_write(32'h00, 32'd3);
        tick();
        bus_write(32'h00, 32'd0);
        tick();
        bus_write(32'h00, 32'd1);
        tick();
        bus_write(32'h00, 32'd3);
        tick();
        bus_read(32'h20, d);
`ifdef RELOCK_STATS_EN
        n_checks++; if (d !== 32'd2 || d !== m_relocks[31:0]) begin n_errors++; $display("FAIL relock_count: got %0d want 2", d); end
`else
        n_checks++; if (d !== 32'd0) begin n_errors++; $display("FAIL relock_count_absent: got %0d want 0", d); end
`endif
        n_checks++; if (int_rst_o !== 1'b1) begin n_errors++; $display("FAIL pre_reset_sweep: got int_rst=%b want 1", int_rst_o); end
        rst = 1'b1;
        #1;
        n_checks++; if (sweep_o !== '0 || int_rst_o !== 1'b0 || active_o !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: got sweep=%0d int_rst=%b active=%b want 0/0/0", sweep_o, int_rst_o, active_o);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_read(32'h00, d);
        n_checks++; if (d !== 32'd0) begin n_errors++; $display("FAIL reset_ctrl: got %h want 0", d); end
        bus_read(32'h20, d);
        n_checks++; if (d !== 32'd0) begin n_errors++; $display("FAIL reset_relock_count: got %0d want 0", d); end
    endtask

    task automatic test_bus();
        logic [31:0] d;
        int          exp;
        bus_write(32'h00, 32'd1);
        n_checks++; if (sys_ack !== 1'b1) begin n_errors++; $display("FAIL bus_write_ack: got %b want 1", sys_ack); end
        sys_addr = 32'h40; sys_ren = 1'b1;
        tick();
        sys_ren = 1'b0;
        n_checks++; if (sys_ack !== 1'b1 || sys_rdata !== '0 || sys_err !== 1'b0) begin
            n_errors++;
            $display("FAIL bus_unmapped: got ack=%b rdata=%h err=%b want 1/0/0", sys_ack, sys_rdata, sys_err);
        end
        tick();
        n_checks++; if (sys_ack !== 1'b0) begin n_errors++; $display("FAIL bus_ack_drop: got %b want 0", sys_ack); end
        bus_write(32'h1C, 32'hF);
        exp = exp_status();
        bus_read(32'h1C, d);
        n_checks++; if (d !== 32'(exp) || d !== 32'd1) begin n_errors++; $display("FAIL bus_status_ro: got %h want %h", d, exp); end
        bus_write(32'h00, 32'd3);
        bus_read(32'h00, d);
        n_checks++; if (d !== 32'd1) begin n_errors++; $display("FAIL bus_ctrl_force_reads0: got %h want 1", d); end
    endtask

    task automatic test_random();
        int hold = 0;
        int exp_st;
        bit rd;
        for (int r = 0; r < 4; r++) begin
            bus_write(32'h04, 32'($urandom_range(0, 6)));
            bus_write(32'h18, 32'($urandom_range(0, 6)));
            if (r == 2) begin
                bus_write(32'h08, 32'd20);
                bus_write(32'h0C, 32'(-5));
            end else begin
                bus_write(32'h08, 32'(int'($urandom_range(0, 50)) - 60));
                bus_write(32'h0C, 32'($urandom_range(10, 60)));
            end
            bus_write(32'h10, 32'((r == 3) ? 0 : $urandom_range(1, 20)));
            bus_write(32'h14, 32'(int'($urandom_range(0, 60)) - 10));
            bus_write(32'h00, 32'd1);
            for (int c = 0; c < 300; c++) begin
                int op = $urandom_range(0, 99);
                if (hold == 0) begin
                    railed_i = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
                    hold     = $urandom_range(1, 8);
                end
                hold--;
                sig_i = 14'(int'($urandom_range(0, 120)) - 60);
                rd = 1'b0;
                if (op < 3) begin
                    sys_addr = 32'h00; sys_wdata = 32'd3; sys_wen = 1'b1;
                end else if (op == 3) begin
                    sys_addr = 32'h00; sys_wdata = 32'd0; sys_wen = 1'b1;
                end else if (op < 6) begin
                    sys_addr = 32'h00; sys_wdata = 32'd1; sys_wen = 1'b1;
                end else begin
                    sys_addr = 32'h1C; sys_ren = 1'b1; rd = 1'b1;
                end
                exp_st = exp_status();
                tick();
                sys_wen = 1'b0; sys_ren = 1'b0;
                n_checks++;
                if (sweep_o !== m_sweep || int_rst_o !== m_int_rst[0] || active_o !== m_active[0]) begin
                    n_errors++;
                    $display("FAIL random_out r%0d c%0d: got sweep=%0d int_rst=%b active=%b want %0d/%0d/%0d",
                             r, c, sweep_o, int_rst_o, active_o, m_sweep, m_int_rst, m_active);
                end
                if (rd) begin
                    n_checks++;
                    if (sys_rdata !== 32'(exp_st)) begin
                        n_errors++;
                        $display("FAIL random_status r%0d c%0d: got %h want %h", r, c, sys_rdata, exp_st);
                    end
                end
            end
            railed_i = 2'b00;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_short_rail();
        test_rail_sweep();
        test_triangle();
        test_lock_settle();
        test_rail_beats_settle();
        test_disable_and_reset();
        test_bus();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
